// File: rtl/wm8731_i2c_word_writer.sv
// I2C master that writes one 16-bit WM8731 control word per transfer:
// START, {DEV_ADDR,W}, word[15:8], word[7:0], STOP, with per-byte ACK check.
module wm8731_i2c_word_writer #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [6:0]  DEV_ADDR = 7'h1A
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        ready,
  input  logic        sda_in,
  output logic        scl,
  output logic        sda_drive_low,
  output logic        busy,
  output logic        done,
  output logic        ack_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

  state_t      state, state_n;
  logic [1:0]  quarter, quarter_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic [9:0]  div_cnt, div_cnt_n;
  logic [15:0] shift_word;
  logic        ack_error_n;
  logic        scl_n, sda_n;
  logic        accept, q_end, tx_bit;
  logic [7:0]  tx_byte;

  assign accept = ready && word_valid;
  assign q_end  = (div_cnt == DIV_LAST);

  // Next-state logic: advances one quarter each time the divider wraps.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_n     = state;
    quarter_n   = quarter;
    bit_idx_n   = bit_idx;
    byte_idx_n  = byte_idx;
    div_cnt_n   = '0;
    ack_error_n = ack_error;

    if (state inside {S_START, S_DATA, S_ACK, S_STOP})
      div_cnt_n = q_end ? 10'd0 : div_cnt + 10'd1;

    case (state)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (accept) begin
          state_n     = S_START;
          quarter_n   = 2'd0;
          bit_idx_n   = 3'd0;
          byte_idx_n  = 2'd0;
          ack_error_n = 1'b0;
        end
      end
      S_START: if (q_end) begin
        if (quarter == 2'd1) begin
          state_n   = S_DATA;
          quarter_n = 2'd0;
        end else begin
          quarter_n = quarter + 2'd1;
        end
      end
      S_DATA: if (q_end) begin
        if (quarter == 2'd3) begin
          quarter_n = 2'd0;
          if (bit_idx == 3'd7) begin
            state_n   = S_ACK;
            bit_idx_n = 3'd0;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          quarter_n = quarter + 2'd1;
        end
      end
      S_ACK: if (q_end) begin
        // Slave level is taken at the end of the second SCL-high quarter.
        if (quarter == 2'd2 && sda_in) ack_error_n = 1'b1;
        if (quarter == 2'd3) begin
          quarter_n = 2'd0;
          if (ack_error || byte_idx == 2'd2) begin
            state_n = S_STOP;
          end else begin
            state_n    = S_DATA;
            byte_idx_n = byte_idx + 2'd1;
          end
        end else begin
          quarter_n = quarter + 2'd1;
        end
      end
      S_STOP: if (q_end) begin
        if (quarter == 2'd2) begin
          state_n   = S_DONE;
          quarter_n = 2'd0;
        end else begin
          quarter_n = quarter + 2'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Line levels for the upcoming quarter, so registered outputs line up with it.
  always_comb begin
    case (byte_idx_n)
      2'd0:    tx_byte = {DEV_ADDR, 1'b0};
      2'd1:    tx_byte = shift_word[15:8];
      default: tx_byte = shift_word[7:0];
    endcase
    tx_bit = tx_byte[3'd7 - bit_idx_n];

    scl_n = 1'b1;
    sda_n = 1'b0;
    case (state_n)
      S_START: begin
        scl_n = (quarter_n == 2'd0);
        sda_n = 1'b1;
      end
      S_DATA: begin
        scl_n = (quarter_n == 2'd1) || (quarter_n == 2'd2);
        sda_n = ~tx_bit;
      end
      S_ACK: begin
        scl_n = (quarter_n == 2'd1) || (quarter_n == 2'd2);
        sda_n = 1'b0;
      end
      S_STOP: begin
        scl_n = (quarter_n != 2'd0);
        sda_n = (quarter_n != 2'd2);
      end
      default: begin
        scl_n = 1'b1;
        sda_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!reset) begin
      state         <= S_IDLE;
      quarter       <= 2'd0;
      bit_idx       <= 3'd0;
      byte_idx      <= 2'd0;
      div_cnt       <= 10'd0;
      ack_error     <= 1'b0;
      scl           <= 1'b1;
      sda_drive_low <= 1'b0;
      ready         <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      quarter       <= quarter_n;
      bit_idx       <= bit_idx_n;
      byte_idx      <= byte_idx_n;
      div_cnt       <= div_cnt_n;
      ack_error     <= ack_error_n;
      scl           <= scl_n;
      sda_drive_low <= sda_n;
      ready         <= (state_n == S_IDLE) || (state_n == S_DONE);
      busy          <= state_n inside {S_START, S_DATA, S_ACK, S_STOP};
      done          <= (state_n == S_DONE);
    end
  end

  // NOTE: pure datapath holding register; it is only read after an accept loads it, so it needs no reset.
  always_ff @(posedge clock) begin
    if (accept) shift_word <= word_in;
  end

endmodule

// File: tb/tb_wm8731_i2c_word_writer.sv
// Bench for wm8731_i2c_word_writer: I2C slave model, SDA/SCL decoder and a
// scoreboard of expected transfers computed from the protocol rules.
module tb_wm8731_i2c_word_writer;

  localparam int unsigned CLK_DIV  = 4;
  localparam logic [6:0]  DEV_ADDR = 7'h1A;

  typedef struct {
    logic [23:0] bytes;
    int          nbytes;
    logic        err;
    int          latency;
    int          accept_cycle;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [15:0] word_in;
  logic        word_valid;
  logic        ready;
  logic        sda_in;
  logic        scl;
  logic        sda_drive_low;
  logic        busy;
  logic        done;
  logic        ack_error;

  logic        slave_pull = 1'b0;
  logic [2:0]  cur_mask   = 3'b000;
  int          cycle      = 0;
  int          n_vec      = 0;
  int          n_miss     = 0;
  exp_t        exp_q[$];

  wm8731_i2c_word_writer #(.CLK_DIV(CLK_DIV), .DEV_ADDR(DEV_ADDR)) dut (
    .clock(clock),
    .reset(reset),
    .word_in(word_in),
    .word_valid(word_valid),
    .ready(ready),
    .sda_in(sda_in),
    .scl(scl),
    .sda_drive_low(sda_drive_low),
    .busy(busy),
    .done(done),
    .ack_error(ack_error)
  );

  // Open-drain SDA: low if either side pulls.
  assign sda_in = ~(sda_drive_low | slave_pull);

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s (cycle %0d)", name, cycle);
  endtask

  // Reference: bytes sent stop at the first NACKed byte; each byte is 9 SCL
  // clocks = 36 quarters, plus 2 START and 3 STOP quarters.
  function automatic exp_t model(input logic [15:0] w, input logic [2:0] mask, input int acc);
    exp_t e;
    int   n;
    n     = 3;
    e.err = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (mask[k]) begin
        n     = k + 1;
        e.err = 1'b1;
      end
    end
    e.bytes        = {DEV_ADDR, 1'b0, w};
    e.nbytes       = n;
    e.latency      = (2 + 36 * n + 3) * CLK_DIV;
    e.accept_cycle = acc;
    return e;
  endfunction

  // Monitor + slave: decode the bus at falling clock edges and score each done pulse.
  initial begin : monitor
    logic       prev_scl, prev_sdl, prev_done;
    int         pos_cnt, scl_rises, starts, stops, nbits;
    logic [7:0] acc;
    logic [7:0] got[$];
    exp_t       e;
    prev_scl  = 1'b1;
    prev_sdl  = 1'b0;
    prev_done = 1'b0;
    pos_cnt   = 0;
    scl_rises = 0;
    starts    = 0;
    stops     = 0;
    nbits     = 0;
    acc       = 8'h00;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        slave_pull = 1'b0;
        prev_scl   = 1'b1;
        prev_sdl   = 1'b0;
        prev_done  = 1'b0;
        pos_cnt    = 0;
        scl_rises  = 0;
        starts     = 0;
        stops      = 0;
        nbits      = 0;
        got.delete();
        continue;
      end
      if (prev_done) check("done_pulse_width", done, 1'b0);
      if (scl && prev_scl && sda_drive_low && !prev_sdl) begin
        pos_cnt   = 0;
        scl_rises = 0;
        nbits     = 0;
        stops     = 0;
        starts    = 1;
        got.delete();
      end else if (scl && prev_scl && !sda_drive_low && prev_sdl) begin
        stops++;
      end
      if (scl && !prev_scl) begin
        scl_rises++;
        pos_cnt++;
        if (pos_cnt % 9 == 0) begin
          if (pos_cnt <= 27) slave_pull = !cur_mask[pos_cnt / 9 - 1];
        end else begin
          acc = {acc[6:0], !sda_drive_low};
          nbits++;
          if (nbits == 8) begin
            got.push_back(acc);
            nbits = 0;
          end
        end
      end
      if (!scl && prev_scl) slave_pull = 1'b0;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          check("latency", cycle - e.accept_cycle, e.latency);
          check("ack_error", ack_error, e.err);
          check("byte_count", got.size(), e.nbytes);
          for (int k = 0; k < e.nbytes && k < got.size(); k++)
            check($sformatf("byte%0d", k), got[k], e.bytes[23 - 8 * k -: 8]);
          check("scl_pulses", scl_rises, 9 * e.nbytes + 1);
          check("start_count", starts, 1);
          check("stop_count", stops, 1);
          check("ready_at_done", ready, 1'b1);
          check("busy_at_done", busy, 1'b0);
        end
      end
      prev_done = (done === 1'b1);
      prev_scl  = scl;
      prev_sdl  = sda_drive_low;
    end
  end

  // Called at a falling edge; returns just after the accepting rising edge.
  task automatic start_txn(input logic [15:0] w, input logic [2:0] m, output int acc);
    int t;
    word_in    = w;
    word_valid = 1'b1;
    t          = 0;
    while (ready !== 1'b1 && t < 1000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 1000) fail_now("accept_timeout");
    @(posedge clock);
    #1;
    acc = cycle;
    exp_q.push_back(model(w, m, acc));
    cur_mask = m;
    @(negedge clock);
    word_valid = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    check("ready_after_accept", ready, 1'b0);
    check("ack_error_cleared", ack_error, 1'b0);
    check("start_q0_scl", scl, 1'b1);
    check("start_q0_sda", sda_drive_low, 1'b1);
  endtask

  task automatic wait_done(output int dcy);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 2000) fail_now("done_timeout");
    dcy = cycle;
  endtask

  // Full transfer with optional word_valid noise while busy; ends in the done cycle.
  task automatic txn(input logic [15:0] w, input logic [2:0] m, input int noise,
                     output int acc, output int dcy);
    start_txn(w, m, acc);
    repeat (noise) begin
      @(negedge clock);
      word_valid = 1'($urandom_range(0, 1));
      word_in    = 16'($urandom);
    end
    @(negedge clock);
    word_valid = 1'b0;
    wait_done(dcy);
  endtask

  initial begin : stimulus
    int         acc, dcy, prev_dcy, noise, gap;
    logic [15:0] w;
    logic [2:0]  m;
    reset      = 1'b0;
    word_valid = 1'b0;
    word_in    = 16'h0000;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_scl", scl, 1'b1);
    check("rst_sda", sda_drive_low, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ack_error", ack_error, 1'b0);

    txn(16'h1E00, 3'b000, 0, acc, dcy);
    repeat (2) @(negedge clock);
    txn(16'h0C00, 3'b001, 0, acc, dcy);
    repeat (2) @(negedge clock);
    txn(16'h1201, 3'b100, 0, acc, dcy);
    @(negedge clock);
    txn(16'h0A5F, 3'b000, 120, acc, dcy);
    prev_dcy = dcy;
    word_in    = 16'h0817;
    word_valid = 1'b1;
    txn(16'h0817, 3'b000, 40, acc, dcy);
    check("b2b_accept_cycle", acc, prev_dcy + 1);

    // Abort with reset at the start of quarter 50.
    @(negedge clock);
    start_txn(16'h0E5A, 3'b000, acc);
    repeat (199) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("abort_scl", scl, 1'b1);
    check("abort_sda", sda_drive_low, 1'b0);
    check("abort_ready", ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    txn(16'h0E5A, 3'b000, 0, acc, dcy);

    for (int i = 0; i < 8; i++) begin
      w     = 16'($urandom);
      m     = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      noise = $urandom_range(0, 150);
      gap   = $urandom_range(0, 2);
      prev_dcy = dcy;
      if (gap != 0) repeat (gap) @(negedge clock);
      txn(w, m, noise, acc, dcy);
      if (gap == 0) check("b2b_accept_cycle", acc, prev_dcy + 1);
    end

    repeat (4) @(negedge clock);
    if (exp_q.size() != 0) fail_now("pending_transfers");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    fail_now("watchdog_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
